// File: rtl/axil_rd_timeout.sv
// +----------------------------------------------------------------------------+
// | axil_rd_timeout                                                            |
// | AXI4-lite read watchdog: forwards one read at a time, returns an error     |
// | response upstream on timeout and drains the abandoned slave transaction.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module axil_rd_timeout #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [1:0]  TIMEOUT_RESP   = 2'b10,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  timeout_event,
  output logic [CNT_WIDTH-1:0]  timeout_count,
  output logic                  draining
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;

  logic w_s_ar_hs;
  logic w_m_ar_hs;
  logic w_m_r_hs;
  logic w_s_r_hs;
  logic w_s_rvalid_hold;
  logic w_at_limit;
  logic w_timeout;

  assign w_s_ar_hs       = s_axil_arvalid && s_axil_arready;
  assign w_m_ar_hs       = m_axil_arvalid && m_axil_arready;
  assign w_m_r_hs        = m_axil_rvalid && m_axil_rready;
  assign w_s_r_hs        = s_axil_rvalid && s_axil_rready;
  assign w_s_rvalid_hold = s_axil_rvalid && !s_axil_rready;
  assign w_at_limit      = (r_timer == TIMER_LAST);

  // A still-unaccepted upstream response cannot be overwritten, so the
  // timeout waits at its limit until that response has been taken.
  assign w_timeout = ((r_state == ADDR) || (r_state == DATA)) && w_at_limit &&
                     !w_m_r_hs && !w_s_rvalid_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      s_axil_arready <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= 2'b00;
      s_axil_rvalid  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arprot  <= 3'b000;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      timeout_event  <= 1'b0;
      timeout_count  <= '0;
      draining       <= 1'b0;
    end else begin
      timeout_event <= 1'b0;
      if (w_s_r_hs) begin
        s_axil_rvalid <= 1'b0;
      end

      if (w_timeout) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= '0;
        s_axil_rresp  <= TIMEOUT_RESP;
        timeout_event <= 1'b1;
        if (timeout_count != '1) begin
          timeout_count <= timeout_count + 1'b1;
        end
        draining <= 1'b1;
        r_state  <= DRAIN;
        if (w_m_ar_hs) begin
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b1;
        end else if (r_state == DATA) begin
          m_axil_rready <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_s_ar_hs) begin
              m_axil_araddr  <= s_axil_araddr;
              m_axil_arprot  <= s_axil_arprot;
              m_axil_arvalid <= 1'b1;
              s_axil_arready <= 1'b0;
              r_timer        <= '0;
              r_state        <= ADDR;
            end else begin
              s_axil_arready <= !m_axil_arvalid;
            end
          end
          ADDR: begin
            if (!w_at_limit) begin
              r_timer <= r_timer + 1'b1;
            end
            if (w_m_ar_hs) begin
              m_axil_arvalid <= 1'b0;
              m_axil_rready  <= !w_s_rvalid_hold;
              r_state        <= DATA;
            end
          end
          DATA: begin
            if (w_m_r_hs) begin
              s_axil_rdata   <= m_axil_rdata;
              s_axil_rresp   <= m_axil_rresp;
              s_axil_rvalid  <= 1'b1;
              m_axil_rready  <= 1'b0;
              s_axil_arready <= 1'b1;
              r_state        <= IDLE;
            end else begin
              if (!w_at_limit) begin
                r_timer <= r_timer + 1'b1;
              end
              m_axil_rready <= !w_s_rvalid_hold;
            end
          end
          DRAIN: begin
            if (w_m_ar_hs) begin
              m_axil_arvalid <= 1'b0;
              m_axil_rready  <= 1'b1;
            end
            // The late beat is consumed here and never reaches upstream.
            if (w_m_r_hs) begin
              m_axil_rready  <= 1'b0;
              draining       <= 1'b0;
              s_axil_arready <= 1'b1;
              r_state        <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_rd_timeout.sv
// +----------------------------------------------------------------------------+
// | tb_axil_rd_timeout                                                         |
// | Directed and randomised reads against a modelled AXI-lite slave.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axil_rd_timeout;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;
  logic        timeout_event;
  logic [15:0] timeout_count;
  logic        draining;

  axil_rd_timeout #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO),
    .TIMEOUT_RESP(2'b10), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .timeout_event(timeout_event), .timeout_count(timeout_count),
    .draining(draining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // slave model configuration and capture
  int          sl_ar_wait = 0;
  int          sl_r_wait  = 0;
  bit          sl_r_never = 1'b0;
  logic [31:0] sl_data    = '0;
  logic [1:0]  sl_resp    = 2'b00;
  logic [31:0] sl_cap_addr = '0;
  logic [2:0]  sl_cap_prot = '0;

  // protocol monitors
  int n_shs   = 0;
  int n_pulse = 0;
  int n_viol  = 0;
  bit ar_pend = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (s_axil_rvalid && s_axil_rready) n_shs <= n_shs + 1;
      if (timeout_event) n_pulse <= n_pulse + 1;
      if (ar_pend && !m_axil_arvalid) n_viol <= n_viol + 1;
      ar_pend <= m_axil_arvalid && !m_axil_arready;
    end else begin
      ar_pend <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave: accepts AR after sl_ar_wait cycles, answers R after sl_r_wait cycles
  initial begin
    m_axil_arready = 1'b0;
    m_axil_rvalid  = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (m_axil_arvalid) begin
        repeat (sl_ar_wait) @(negedge clk);
        m_axil_arready = 1'b1;
        sl_cap_addr    = m_axil_araddr;
        sl_cap_prot    = m_axil_arprot;
        @(negedge clk);
        m_axil_arready = 1'b0;
        while (sl_r_never) @(negedge clk);
        repeat (sl_r_wait) @(negedge clk);
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = sl_data;
        m_axil_rresp  = sl_resp;
        while (!m_axil_rready) @(negedge clk);
        @(negedge clk);
        m_axil_rvalid = 1'b0;
        m_axil_rdata  = '0;
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [1:0] sresp, input int arw, input int rw,
                         input bit exp_to, input int stall,
                         output int lat, output bit ev_at);
    exp_t e;
    exp_t got;
    int   b;
    if (exp_to) sb.push_back('{d: 32'h0, r: 2'b10});
    else        sb.push_back('{d: sdata, r: sresp});
    sl_data    = sdata;
    sl_resp    = sresp;
    sl_ar_wait = arw;
    sl_r_wait  = rw;
    @(negedge clk);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = addr;
    s_axil_arprot  = 3'b010;
    b = 0;
    while (!s_axil_arready && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("ar_accept_timely", 64'(b < 100), 64'd1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    lat = 1;
    while (!s_axil_rvalid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("r_seen_timely", 64'(s_axil_rvalid), 64'd1);
    ev_at = timeout_event;
    got   = '{d: s_axil_rdata, r: s_axil_rresp};
    repeat (stall) begin
      @(negedge clk);
      chk("stall_rvalid", 64'(s_axil_rvalid), 64'd1);
      chk("stall_rdata", 64'({s_axil_rdata, s_axil_rresp}), 64'({got.d, got.r}));
      chk("stall_m_rready", 64'(m_axil_rready && !draining), 64'd0);
    end
    e = sb.pop_front();
    chk("rdata", 64'(s_axil_rdata), 64'(e.d));
    chk("rresp", 64'(s_axil_rresp), 64'(e.r));
    s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_rready = 1'b0;
    chk("rvalid_clear", 64'(s_axil_rvalid), 64'd0);
  endtask

  task automatic wait_drain_done();
    int b;
    b = 0;
    while (draining && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("drain_done", 64'(draining), 64'd0);
  endtask

  initial begin
    int   lat;
    bit   ev;
    int   exp_cnt;
    int   exp_pulse;
    int   n_reads;
    logic [31:0] d;
    exp_cnt   = 0;
    exp_pulse = 0;
    n_reads   = 0;
    rst_n          = 1'b0;
    s_axil_araddr  = '0;
    s_axil_arprot  = '0;
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_s_arready", 64'(s_axil_arready), 64'd0);
    chk("rst_s_rvalid", 64'(s_axil_rvalid), 64'd0);
    chk("rst_m_arvalid", 64'(m_axil_arvalid), 64'd0);
    chk("rst_m_rready", 64'(m_axil_rready), 64'd0);
    chk("rst_draining", 64'(draining), 64'd0);
    chk("rst_count", 64'(timeout_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arready_after_rst", 64'(s_axil_arready), 64'd1);

    // normal read
    do_read(32'h1000, 32'hDEADBEEF, 2'b00, 0, 3, 1'b0, 0, lat, ev);
    n_reads++;
    chk("normal_addr", 64'(sl_cap_addr), 64'h1000);
    chk("normal_prot", 64'(sl_cap_prot), 64'd2);
    chk("normal_count", 64'(timeout_count), 64'd0);

    // zero-wait latency
    do_read(32'h1004, 32'h0BADF00D, 2'b00, 0, 0, 1'b0, 0, lat, ev);
    n_reads++;
    chk("zero_wait_latency", 64'(lat), 64'd3);

    // R timeout, slave never answers until released
    sl_r_never = 1'b1;
    do_read(32'h1008, 32'h55AA55AA, 2'b00, 0, 0, 1'b1, 0, lat, ev);
    n_reads++; exp_cnt++; exp_pulse++;
    chk("rto_latency", 64'(lat), 64'(TO + 1));
    chk("rto_event", 64'(ev), 64'd1);
    chk("rto_count", 64'(timeout_count), 64'(exp_cnt));
    chk("rto_draining", 64'(draining), 64'd1);
    chk("rto_event_pulse", 64'(timeout_event), 64'd0);
    sl_r_never = 1'b0;
    wait_drain_done();
    chk("rto_no_late_beat", 64'(s_axil_rvalid), 64'd0);

    // AR timeout then drain
    do_read(32'h100C, 32'h12345678, 2'b00, 40, 2, 1'b1, 0, lat, ev);
    n_reads++; exp_cnt++; exp_pulse++;
    chk("arto_draining", 64'(draining), 64'd1);
    chk("arto_m_arvalid", 64'(m_axil_arvalid), 64'd1);
    wait_drain_done();
    chk("arto_no_late_beat", 64'(n_shs), 64'(n_reads));
    do_read(32'h2000, 32'hA5A5F00F, 2'b00, 0, 1, 1'b0, 0, lat, ev);
    n_reads++;
    chk("after_drain_addr", 64'(sl_cap_addr), 64'h2000);

    // R handshake exactly in the last timer cycle wins
    do_read(32'h3000, 32'hCAFEF00D, 2'b00, 0, TO - 2, 1'b0, 0, lat, ev);
    n_reads++;
    chk("race_event", 64'(ev), 64'd0);
    chk("race_count", 64'(timeout_count), 64'(exp_cnt));

    // one cycle later the timeout wins
    do_read(32'h3004, 32'hFEEDFACE, 2'b00, 0, TO - 1, 1'b1, 0, lat, ev);
    n_reads++; exp_cnt++; exp_pulse++;
    chk("late_count", 64'(timeout_count), 64'(exp_cnt));
    wait_drain_done();

    // upstream backpressure
    do_read(32'h4000, 32'h13572468, 2'b01, 0, 2, 1'b0, 10, lat, ev);
    n_reads++;

    // random stalls on both sides
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      do_read($urandom, d, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
              $urandom_range(0, 5), 1'b0, $urandom_range(0, 3), lat, ev);
      n_reads++;
    end

    chk("total_upstream_responses", 64'(n_shs), 64'(n_reads));
    chk("total_timeout_pulses", 64'(n_pulse), 64'(exp_pulse));
    chk("arvalid_never_dropped", 64'(n_viol), 64'd0);
    chk("final_count", 64'(timeout_count), 64'(exp_cnt));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    // asynchronous reset in the middle of DATA
    sl_ar_wait = 0;
    sl_r_wait  = 10;
    @(negedge clk);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 32'h5000;
    while (!s_axil_arready) @(negedge clk);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_data_rready", 64'(m_axil_rready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s_arready", 64'(s_axil_arready), 64'd0);
    chk("arst_s_rvalid", 64'(s_axil_rvalid), 64'd0);
    chk("arst_m_arvalid", 64'(m_axil_arvalid), 64'd0);
    chk("arst_m_rready", 64'(m_axil_rready), 64'd0);
    chk("arst_draining", 64'(draining), 64'd0);
    chk("arst_count", 64'(timeout_count), 64'd0);
    chk("arst_event", 64'(timeout_event), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
